// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ID/EX ALU decode stage.
//   - XLEN default datapath width
//   - CTRL_W and the fixed 4-bit ALU control encodings (ALU_ADD..ALU_SRA)
//   - RV32I major opcode constants (OPC_*)
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;

    // ALU control word. For OP/OP-IMM the low three bits are funct3 and
    // bit 3 is funct7[5], so these values line up with the instruction fields.
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/alu_dec_comb.sv
// alu_dec_comb: purely combinational RV32I decode into ALU control and operands.
// Ports:
//   instr    in  32    raw instruction
//   pc       in  XLEN  pc of instr
//   rs1_data in  XLEN  register file read port 1
//   rs2_data in  XLEN  register file read port 2
//   ctrl     out 4     ALU control word
//   d1, d2   out XLEN  ALU operands
//   we       out 1     writeback enable (already cleared for rd == x0)
//   illegal  out 1     undecodable instruction
// Build option: define ALU_DEC_ILLEGAL_CHECK_EN to flag malformed encodings
// (illegal = 1, we = 0). Without it, illegal is tied 0 and only funct7[5]
// is looked at.
module alu_dec_comb #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [31:0]                instr,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    output logic [alu_pkg::CTRL_W-1:0] ctrl,
    output logic [XLEN-1:0]            d1,
    output logic [XLEN-1:0]            d2,
    output logic                       we,
    output logic                       illegal
);
    import alu_pkg::*;

`ifdef ALU_DEC_ILLEGAL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       f7_ok;

    // Immediates built at 32 bits, then sign-extended to XLEN.
    logic signed [31:0] imm_i32;
    logic signed [31:0] imm_s32;
    logic signed [31:0] imm_u32;
    logic [XLEN-1:0]    imm_i;
    logic [XLEN-1:0]    imm_s;
    logic [XLEN-1:0]    imm_u;

    logic we_raw;
    logic bad;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign f7_ok   = (f7 == 7'b0000000) || (f7 == 7'b0100000);

    assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
    assign imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u32 = {instr[31:12], 12'b0};
    assign imm_i   = XLEN'(imm_i32);
    assign imm_s   = XLEN'(imm_s32);
    assign imm_u   = XLEN'(imm_u32);

    always_comb begin
        ctrl   = ALU_ADD;
        d1     = '0;
        d2     = '0;
        we_raw = 1'b0;
        bad    = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                ctrl   = {f7[5], f3};
                d1     = rs1_data;
                d2     = rs2_data;
                we_raw = 1'b1;
                // funct7 = 0100000 is only meaningful for SUB and SRA
                bad    = !f7_ok || (f7[5] && (f3 != 3'b000) && (f3 != 3'b101));
            end
            OPC_OPIMM: begin
                // Only the right shifts use funct7[5]; for the other ops
                // those bits belong to the immediate.
                ctrl   = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
                d1     = rs1_data;
                d2     = imm_i;
                we_raw = 1'b1;
                bad    = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                         ((f3 == 3'b101) && !f7_ok);
            end
            OPC_LUI: begin
                d2     = imm_u;
                we_raw = 1'b1;
            end
            OPC_AUIPC: begin
                d1     = pc;
                d2     = imm_u;
                we_raw = 1'b1;
            end
            OPC_LOAD: begin
                d1     = rs1_data;
                d2     = imm_i;
                we_raw = 1'b1;
            end
            OPC_STORE: begin
                d1     = rs1_data;
                d2     = imm_s;
            end
            OPC_JAL, OPC_JALR: begin
                // The ALU produces the link value pc + 4; targets are
                // computed elsewhere.
                d1     = pc;
                d2     = XLEN'(4);
                we_raw = 1'b1;
            end
            OPC_BRANCH: begin
                d1 = rs1_data;
                d2 = rs2_data;
                unique case (f3[2:1])
                    2'b00:   ctrl = ALU_SUB;   // BEQ/BNE compare via zero flag
                    2'b10:   ctrl = ALU_SLT;   // BLT/BGE
                    2'b11:   ctrl = ALU_SLTU;  // BLTU/BGEU
                    default: begin
                        ctrl = ALU_ADD;
                        bad  = 1'b1;           // f3 010/011 are reserved
                    end
                endcase
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    assign illegal = CHECK_EN && bad;
    assign we      = we_raw && (rd != 5'd0) && !illegal;

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: ID/EX stage producing ALU control and operands behind a
// single-entry valid/ready output register (1-cycle latency, full throughput).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   flush                             drop held entry and same-cycle input
//   in_valid/in_ready                 upstream handshake
//   in_instr, in_pc, in_rs1_data, in_rs2_data  instruction and operands
//   out_valid/out_ready               downstream (EX) handshake
//   out_ctrl, out_d1, out_d2          ALU control and operands
//   out_rd, out_we, out_illegal       writeback info and decode error
// Build option: ALU_DEC_ILLEGAL_CHECK_EN enables illegal-encoding detection
// inside alu_dec_comb.
module alu_decode_stage #(
    parameter int XLEN   = alu_pkg::XLEN,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_d1,
    output logic [XLEN-1:0]   out_d2,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_illegal
);
    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_d1;
    logic [XLEN-1:0]   dec_d2;
    logic              dec_we;
    logic              dec_illegal;

    logic              valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [XLEN-1:0]   d1_reg;
    logic [XLEN-1:0]   d2_reg;
    logic [4:0]        rd_reg;
    logic              we_reg;
    logic              illegal_reg;
    logic              accept;

    alu_dec_comb #(.XLEN(XLEN)) u_dec (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .ctrl     (dec_ctrl),
        .d1       (dec_d1),
        .d2       (dec_d2),
        .we       (dec_we),
        .illegal  (dec_illegal)
    );

    // Ready whenever the slot is empty or being drained this cycle, so a
    // steady stream passes with no bubble.
    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            d1_reg      <= '0;
            d2_reg      <= '0;
            rd_reg      <= '0;
            we_reg      <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (flush) begin
            // Data fields keep stale values; only valid matters downstream.
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            ctrl_reg    <= dec_ctrl;
            d1_reg      <= dec_d1;
            d2_reg      <= dec_d2;
            rd_reg      <= in_instr[11:7];
            we_reg      <= dec_we;
            illegal_reg <= dec_illegal;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid   = valid_reg;
    assign out_ctrl    = ctrl_reg;
    assign out_d1      = d1_reg;
    assign out_d2      = d2_reg;
    assign out_rd      = rd_reg;
    assign out_we      = we_reg;
    assign out_illegal = illegal_reg;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed, table-driven check of alu_decode_stage plus
// hand-written handshake sequences (backpressure, flush, async reset).
// Expected illegal/we values follow ALU_DEC_ILLEGAL_CHECK_EN when defined.
module tb_alu_decode_stage;

`ifdef ALU_DEC_ILLEGAL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_ctrl;
    logic [31:0] out_d1;
    logic [31:0] out_d2;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_d1      (out_d1),
        .out_d2      (out_d2),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        we;   // expected we with checking disabled
        logic        bad;  // flagged illegal when checking is enabled
    } vec_t;

    localparam int NV = 18;
    vec_t  vecs [NV];
    string names [NV];

    function automatic logic [75:0] pk(logic v, logic [3:0] c, logic [31:0] a,
                                       logic [31:0] b, logic [4:0] r, logic w, logic i);
        return {v, c, a, b, r, w, i};
    endfunction

    function automatic logic [75:0] got();
        return {out_valid, out_ctrl, out_d1, out_d2, out_rd, out_we, out_illegal};
    endfunction

    task automatic check(input string name, input logic [75:0] actual, input logic [75:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            $display("ok   %s: %h", name, actual);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    initial begin
        logic [75:0] sub_exp;
        logic [75:0] lui_exp;

        //               instr         pc          rs1         rs2        ctrl   d1           d2           rd  we  bad
        vecs[0]  = '{32'h402081B3, 32'h0,   32'd10,       32'd3,   4'b1000, 32'd10,       32'd3,       5'd3,  1, 0}; names[0]  = "SUB x3,x1,x2";
        vecs[1]  = '{32'h40335293, 32'h0,   32'h80000000, 32'h0,   4'b1101, 32'h80000000, 32'h00000403, 5'd5, 1, 0}; names[1]  = "SRAI x5,x6,3";
        vecs[2]  = '{32'hC0008393, 32'h0,   32'h1000,     32'h55,  4'b0000, 32'h1000,     32'hFFFFFC00, 5'd7, 1, 0}; names[2]  = "ADDI imm 0xC00";
        vecs[3]  = '{32'h123450B7, 32'h0,   32'hDEADBEEF, 32'h1,   4'b0000, 32'h0,        32'h12345000, 5'd1, 1, 0}; names[3]  = "LUI x1,0x12345";
        vecs[4]  = '{32'hFFFFF117, 32'h100, 32'h7,        32'h8,   4'b0000, 32'h100,      32'hFFFFF000, 5'd2, 1, 0}; names[4]  = "AUIPC pc 0x100";
        vecs[5]  = '{32'hFFC2A203, 32'h0,   32'h2000,     32'h0,   4'b0000, 32'h2000,     32'hFFFFFFFC, 5'd4, 1, 0}; names[5]  = "LW x4,-4(x5)";
        vecs[6]  = '{32'hFE62AC23, 32'h0,   32'h3000,     32'h77,  4'b0000, 32'h3000,     32'hFFFFFFF8, 5'd24, 0, 0}; names[6] = "SW x6,-8(x5)";
        vecs[7]  = '{32'h008000EF, 32'h200, 32'h5,        32'h6,   4'b0000, 32'h200,      32'h4,        5'd1, 1, 0}; names[7]  = "JAL x1";
        vecs[8]  = '{32'h00008067, 32'h300, 32'h5,        32'h6,   4'b0000, 32'h300,      32'h4,        5'd0, 0, 0}; names[8]  = "JALR x0 (rd0)";
        vecs[9]  = '{32'h00208063, 32'h0,   32'd5,        32'd6,   4'b1000, 32'd5,        32'd6,        5'd0, 0, 0}; names[9]  = "BEQ";
        vecs[10] = '{32'h00204063, 32'h0,   32'd5,        32'd6,   4'b0010, 32'd5,        32'd6,        5'd0, 0, 0}; names[10] = "BLT";
        vecs[11] = '{32'h00206063, 32'h0,   32'd5,        32'd6,   4'b0011, 32'd5,        32'd6,        5'd0, 0, 0}; names[11] = "BLTU";
        vecs[12] = '{32'h002091B3, 32'h0,   32'd1,        32'd4,   4'b0001, 32'd1,        32'd4,        5'd3, 1, 0}; names[12] = "SLL";
        vecs[13] = '{32'h0020F1B3, 32'h0,   32'hF0F0,     32'hFF,  4'b0111, 32'hF0F0,     32'hFF,       5'd3, 1, 0}; names[13] = "AND";
        vecs[14] = '{32'h0050B193, 32'h0,   32'd9,        32'd0,   4'b0011, 32'd9,        32'd5,        5'd3, 1, 0}; names[14] = "SLTIU x3,x1,5";
        vecs[15] = '{32'hFFFFFFFF, 32'h40,  32'd9,        32'd8,   4'b0000, 32'h0,        32'h0,        5'd31, 0, 1}; names[15] = "opcode 0x7F";
        vecs[16] = '{32'h022081B3, 32'h0,   32'd10,       32'd3,   4'b0000, 32'd10,       32'd3,        5'd3, 1, 1}; names[16] = "ADD f7=0000001";
        vecs[17] = '{32'h00208033, 32'h0,   32'd10,       32'd3,   4'b0000, 32'd10,       32'd3,        5'd0, 0, 0}; names[17] = "ADD x0 (rd0)";

        // Reset state while rst_n is held low
        #2;
        check("reset outputs", got(), pk(0, 4'b0, 32'h0, 32'h0, 5'd0, 0, 0));
        check("reset in_ready", 76'(in_ready), 76'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one accept per cycle with out_ready high
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check(names[i], got(),
                  pk(1'b1, vecs[i].ctrl, vecs[i].d1, vecs[i].d2, vecs[i].rd,
                     (CHK && vecs[i].bad) ? 1'b0 : vecs[i].we,
                     CHK && vecs[i].bad));
        end

        // Backpressure: hold SUB for 3 cycles while a LUI waits upstream
        sub_exp = pk(1, 4'b1000, 32'd10, 32'd3, 5'd3, 1, 0);
        lui_exp = pk(1, 4'b0000, 32'h0, 32'h12345000, 5'd1, 1, 0);
        @(negedge clk);
        drive(32'h402081B3, 32'h0, 32'd10, 32'd3);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp accept SUB", got(), sub_exp);
        drive(32'h123450B7, 32'h0, 32'hDEADBEEF, 32'h1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp in_ready low c%0d", c), 76'(in_ready), 76'(0));
            @(negedge clk);
            check($sformatf("bp hold c%0d", c), got(), sub_exp);
        end
        out_ready = 1'b1;
        #1;
        check("bp in_ready on drain", 76'(in_ready), 76'(1));
        @(negedge clk);
        check("bp back-to-back LUI", got(), lui_exp);
        in_valid = 1'b0;
        @(negedge clk);
        check("consume no accept", 76'(out_valid), 76'(0));

        // Flush in the same cycle as an accept
        drive(32'h402081B3, 32'h0, 32'd10, 32'd3);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("flush with accept", 76'(out_valid), 76'(0));
        // Flush of a held entry
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("accept before flush", got(), sub_exp);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        check("flush held entry", 76'(out_valid), 76'(0));
        flush = 1'b0;

        // Async reset during a hold with a new instruction pending
        drive(32'h002091B3, 32'h0, 32'd1, 32'd4);
        in_valid = 1'b1;
        @(negedge clk);
        check("hold before reset", got(), pk(1, 4'b0001, 32'd1, 32'd4, 5'd3, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset mid-hold", got(), pk(0, 4'b0, 32'h0, 32'h0, 5'd0, 0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("idle after reset", 76'(out_valid), 76'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- ID/EX pipeline stage that produces the 4-bit ALU control word and both ALU operands (`d1`, `d2`) from a fetched RV32I instruction and its register-file read data.
- Registers the results behind a valid/ready handshake, so the ALU sees stable operands for the whole EX cycle.
- Sits between the register file and the ALU, and is the sole producer of ALU control encodings.

Parameters:
- XLEN, 32, datapath width for pc, register data and operands.
- CTRL_W, 4, ALU control width; fixed encoding, not to be changed.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill held and incoming instruction (branch redirect)
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  pc of in_instr
- in_rs1_data  in  XLEN  register file read port 1
- in_rs2_data  in  XLEN  register file read port 2
- out_valid  out  1  held entry valid for EX
- out_ready  in  1  EX consumes entry
- out_ctrl  out  CTRL_W  ALU control
- out_d1  out  XLEN  ALU operand 1
- out_d2  out  XLEN  ALU operand 2
- out_rd  out  5  destination register (instr[11:7])
- out_we  out  1  register writeback enable
- out_illegal  out  1  instruction not decodable

Behaviour:
- Single-entry output register; latency 1 cycle from accept to out_valid.
- in_ready = !out_valid || out_ready (combinational; full-throughput, no bubble).
- Accept when in_valid && in_ready: load all out_* fields, set out_valid = 1.
- Consume without accept: out_valid clears to 0.
- Hold: out_valid && !out_ready keeps every out_* stable.
- flush (synchronous, highest priority): next cycle out_valid = 0, and any same-cycle input is discarded. Data fields may keep stale values.
- Reset (async, at any time including mid-handshake): out_valid = 0, out_ctrl = 4'b0000, and out_d1, out_d2, out_rd, out_we, out_illegal all 0.
- ALU control encoding:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, OR 0110, AND 0111
  - SUB 1000, SRA 1101
- Decode by opcode (instr[6:0]):
  - OP 0110011: ctrl = {f7[5], f3}; d1 = rs1, d2 = rs2; we = 1.
  - OP-IMM 0010011: ctrl = {(f3==101) ? f7[5] : 0, f3}; d1 = rs1; d2 = sign-extended instr[31:20]; we = 1.
  - LUI 0110111: ADD; d1 = 0; d2 = {instr[31:12], 12'b0}; we = 1.
  - AUIPC 0010111: ADD; d1 = pc; d2 = U-imm; we = 1.
  - LOAD 0000011: ADD; d1 = rs1; d2 = I-imm; we = 1.
  - STORE 0100011: ADD; d1 = rs1; d2 = S-imm; we = 0.
  - JAL 1101111 / JALR 1100111: ADD; d1 = pc; d2 = 4 (link value); we = 1.
  - BRANCH 1100011: d1 = rs1, d2 = rs2, we = 0; f3 000/001 -> SUB, 100/101 -> SLT, 110/111 -> SLTU.
  - Any other opcode: ctrl ADD, d1 = d2 = 0, we = 0.
- out_rd == 0 forces out_we = 0.
- Arithmetic: immediates sign-extended to XLEN. AUIPC and JAL do not add here; they only present operands to the ALU.

Optional Feature:
- Macro ALU_DEC_ILLEGAL_CHECK_EN.
- Defined: out_illegal = 1 and out_we = 0 for any of:
  - an undefined opcode;
  - OP with f7 not in {0000000, 0100000}, or f7 = 0100000 with f3 not in {000, 101};
  - OP-IMM shift with an illegal f7;
  - BRANCH f3 010/011.
- Not defined: out_illegal is tied 0. Undefined opcodes still decode as ADD with d1 = d2 = 0 and we = 0; malformed f7 is ignored (only f7[5] is used).

Decomposition:
- Package alu_pkg holds:
  - ALU_ADD..ALU_SRA control localparams;
  - opcode constants (OPC_OP, OPC_OPIMM, ...);
  - XLEN default.
- Sub-module alu_dec_comb: purely combinational instr/pc/rs data -> ctrl, d1, d2, we, illegal.
- The top level contains only the handshake and the output register.

Test Plan:
- SUB x3,x1,x2 (0x402081B3), rs1 = 10, rs2 = 3, out_ready = 1 -> next cycle out_valid = 1, ctrl 1000, d1 = 10, d2 = 3, rd = 3, we = 1.
- SRAI x5,x6,3 (0x40335293) -> ctrl 1101, d2 = 0x00000403, rd = 5; ADDI with f7-like bits set -> ctrl 0000.
- LUI x1,0x12345 (0x123450B7) -> ctrl 0000, d1 = 0, d2 = 0x12345000; AUIPC at pc 0x100 -> d1 = 0x100.
- Backpressure: out_ready = 0 for 3 cycles after an accept -> in_ready = 0 and outputs stable. Then out_ready = 1 with in_valid = 1 -> back-to-back accept, no bubble.
- flush asserted in the same cycle as an accept -> out_valid = 0 next cycle. Asserting rst_n low mid-hold -> all outputs 0 immediately.
- 0xFFFFFFFF, and ADD with f7 = 0000001 -> out_illegal = 1, we = 0 with the macro; out_illegal = 0 without it.
